// File: rtl/deser_pkg.sv
// Shared definitions for the serial deserializer.
//   DEFAULT_WIDTH : default deserialized word width
//   out_state_e   : output-register occupancy (EMPTY / FULL)
package deser_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [0:0] {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } out_state_e;

endpackage

// File: rtl/serial_deser_bit_shifter.sv
// Serial-to-parallel shift register with bit counter.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   en, d      : bit-valid qualifier and serial data bit
//   clear      : discard the partial word (wins over en)
//   word_done  : high during the cycle whose rising edge accepts the last bit
//   word       : assembled word including the current d; meaningful with word_done
//   bit_cnt    : bits held in the partial word, 0..WIDTH-1
module bit_shifter
   import deser_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     d,
   input  logic                     clear,
   output logic                     word_done,
   output logic [WIDTH-1:0]         word,
   output logic [$clog2(WIDTH)-1:0] bit_cnt
);

   localparam int             CW       = $clog2(WIDTH);
   localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0]  CNT_ONE  = CW'(1'b1);

   logic [WIDTH-1:0] shift_r;
   logic [CW-1:0]    cnt_r;
   logic [WIDTH-1:0] shifted_s;
   logic             take_s;

   // Next shift value and completion strobe; the strobe is combinational so
   // the top can load the word on the very edge that completes it.
   always_comb begin
      shifted_s = {WIDTH{1'b0}};
      if (MSB_FIRST) begin
         shifted_s = {shift_r[WIDTH-2:0], d};
      end else begin
         shifted_s = {d, shift_r[WIDTH-1:1]};
      end
      take_s    = en & ~clear;
      word_done = take_s & (cnt_r == CNT_LAST);
      word      = shifted_s;
      bit_cnt   = cnt_r;
   end

   // Partial word and counter; a completed word restarts from an empty register.
   always_ff @(posedge clk) begin
      if (rst) begin
         shift_r <= {WIDTH{1'b0}};
         cnt_r   <= {CW{1'b0}};
      end else if (clear) begin
         shift_r <= {WIDTH{1'b0}};
         cnt_r   <= {CW{1'b0}};
      end else if (take_s) begin
         if (word_done) begin
            shift_r <= {WIDTH{1'b0}};
            cnt_r   <= {CW{1'b0}};
         end else begin
            shift_r <= shifted_s;
            cnt_r   <= cnt_r + CNT_ONE;
         end
      end else begin
         shift_r <= shift_r;
         cnt_r   <= cnt_r;
      end
   end

endmodule

// File: rtl/serial_deser.sv
// Serial deserializer with a single-word output buffer and valid/ready handoff.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   en, d    : bit-valid qualifier and serial data bit
//   clear    : drop partial word and clear overrun; buffered word is kept
//   data     : completed word, stable while valid=1
//   valid    : data holds an unconsumed word
//   ready    : downstream takes data on edges with valid=1 and ready=1
//   overrun  : sticky, a completed word was dropped because the buffer was full
//   bit_cnt  : bits of the current partial word
module serial_deser
   import deser_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     d,
   input  logic                     clear,
   output logic [WIDTH-1:0]         data,
   output logic                     valid,
   input  logic                     ready,
   output logic                     overrun,
   output logic [$clog2(WIDTH)-1:0] bit_cnt
);

   out_state_e       state_r;
   out_state_e       state_next_s;
   logic [WIDTH-1:0] data_r;
   logic             overrun_r;
   logic             word_done_s;
   logic [WIDTH-1:0] word_s;
   logic             load_s;
   logic             drop_s;

   bit_shifter #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_shifter (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .d         (d),
      .clear     (clear),
      .word_done (word_done_s),
      .word      (word_s),
      .bit_cnt   (bit_cnt)
   );

   // Output-buffer state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= EMPTY;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next state plus load/drop decode. A completion while FULL loads only if
   // the current word leaves on the same edge, giving bubble-free streaming.
   always_comb begin
      state_next_s = state_r;
      load_s       = 1'b0;
      drop_s       = 1'b0;
      case (state_r)
         EMPTY: begin
            if (word_done_s) begin
               load_s       = 1'b1;
               state_next_s = FULL;
            end else begin
               state_next_s = EMPTY;
            end
         end
         FULL: begin
            if (word_done_s && ready) begin
               load_s       = 1'b1;
               state_next_s = FULL;
            end else if (word_done_s) begin
               drop_s       = 1'b1;
               state_next_s = FULL;
            end else if (ready) begin
               state_next_s = EMPTY;
            end else begin
               state_next_s = FULL;
            end
         end
         default: begin
            state_next_s = EMPTY;
         end
      endcase
   end

   // Output word and sticky overrun; clear resets overrun but never the buffer.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_r    <= {WIDTH{1'b0}};
         overrun_r <= 1'b0;
      end else begin
         if (load_s) begin
            data_r <= word_s;
         end else begin
            data_r <= data_r;
         end
         if (clear) begin
            overrun_r <= 1'b0;
         end else if (drop_s) begin
            overrun_r <= 1'b1;
         end else begin
            overrun_r <= overrun_r;
         end
      end
   end

   // Output decode straight from registers.
   always_comb begin
      valid   = (state_r == FULL);
      data    = data_r;
      overrun = overrun_r;
   end

endmodule

// File: tb/tb_serial_deser.sv
module tb_serial_deser;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         en = 1'b0;
   logic         d = 1'b0;
   logic         clear = 1'b0;
   logic         ready = 1'b0;
   logic [W-1:0] data_m, data_l;
   logic         valid_m, valid_l, ovr_m, ovr_l;
   logic [2:0]   cnt_m, cnt_l;

   serial_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
      .clk(clk), .rst(rst), .en(en), .d(d), .clear(clear),
      .data(data_m), .valid(valid_m), .ready(ready), .overrun(ovr_m), .bit_cnt(cnt_m));

   serial_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
      .clk(clk), .rst(rst), .en(en), .d(d), .clear(clear),
      .data(data_l), .valid(valid_l), .ready(ready), .overrun(ovr_l), .bit_cnt(cnt_l));

   always #5 clk = ~clk;

   // Reference model: list of received bits, one-word buffer, sticky flag.
   bit           pbits[$];
   logic [W-1:0] q_m[$];
   logic [W-1:0] q_l[$];
   bit           exp_valid = 1'b0;
   bit           exp_ovr   = 1'b0;
   bit           exp_zero  = 1'b1;
   int           n_cmp = 0;
   int           n_bad = 0;
   bit           mon_on = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] assemble(input bit msb);
      logic [W-1:0] w = '0;
      for (int i = 0; i < W; i++) begin
         if (pbits[i]) w = w | (msb ? (8'd1 << (W - 1 - i)) : (8'd1 << i));
      end
      return w;
   endfunction

   task automatic model(input bit r, input bit c, input bit e, input bit dd, input bit rdy);
      bit done = 1'b0;
      bit consumed;
      logic [W-1:0] wm, wl;
      if (r) begin
         pbits.delete(); q_m.delete(); q_l.delete();
         exp_valid = 1'b0; exp_ovr = 1'b0; exp_zero = 1'b1;
         return;
      end
      consumed = exp_valid && rdy;
      if (c) begin
         pbits.delete();
         exp_ovr = 1'b0;
      end else if (e) begin
         pbits.push_back(dd);
         if (pbits.size() == W) begin
            wm = assemble(1'b1);
            wl = assemble(1'b0);
            pbits.delete();
            done = 1'b1;
         end
      end
      if (done) begin
         if (!exp_valid || rdy) begin
            exp_valid = 1'b1;
            exp_zero  = 1'b0;
            q_m.push_back(wm);
            q_l.push_back(wl);
         end else begin
            exp_ovr = 1'b1;
         end
      end else if (consumed) begin
         exp_valid = 1'b0;
      end
   endtask

   // One clock: drive inputs well away from the edge, update model after it.
   task automatic step(input bit r, input bit c, input bit e, input bit dd, input bit rdy);
      rst = r; clear = c; en = e; d = dd; ready = rdy;
      @(posedge clk);
      model(r, c, e, dd, rdy);
      #2;
   endtask

   // Sends bits v[7] first; optional en=0 gap after every bit.
   task automatic send(input logic [7:0] v, input bit gap, input bit rdy);
      for (int i = 7; i >= 0; i--) begin
         step(1'b0, 1'b0, 1'b1, v[i], rdy);
         if (gap) step(1'b0, 1'b0, 1'b0, 1'($urandom), rdy);
      end
   endtask

   // Monitor: status vs model each mid-cycle; scoreboard pop on handoff.
   always @(negedge clk) begin
      if (mon_on) begin
         chk("valid_m", valid_m, exp_valid);
         chk("valid_l", valid_l, exp_valid);
         chk("bit_cnt_m", cnt_m, pbits.size());
         chk("bit_cnt_l", cnt_l, pbits.size());
         chk("overrun_m", ovr_m, exp_ovr);
         chk("overrun_l", ovr_l, exp_ovr);
         if (exp_zero) begin
            chk("data_zero_m", data_m, 0);
            chk("data_zero_l", data_l, 0);
         end
         if (valid_m) begin
            if (q_m.size() == 0) begin
               chk("sb_depth", q_m.size(), 1);
            end else begin
               chk("data_m", data_m, q_m[0]);
               chk("data_l", data_l, q_l[0]);
               if (ready) begin
                  void'(q_m.pop_front());
                  void'(q_l.pop_front());
               end
            end
         end
      end
   end

   initial begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      mon_on = 1'b1;
      // A5 with continuous en and ready
      send(8'hA5, 1'b0, 1'b1);
      repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      // gapped bits: A5 then 1,1,0,0,0,0,0,0 (LSB-first instance sees 8'h03)
      send(8'hA5, 1'b1, 1'b1);
      send(8'hC0, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      // overrun: 3C kept, FF dropped
      send(8'h3C, 1'b0, 1'b0);
      send(8'hFF, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      // back-to-back 01, 02
      send(8'h01, 1'b0, 1'b1);
      send(8'h02, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      // partial word, clear together with en, then C3
      send(8'hFF, 1'b0, 1'b0);
      send(8'hAA, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      send(8'hC3, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      // reset with a buffered word and 5 partial bits
      send(8'h5A, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'($urandom), 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      send(8'h96, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         step(($urandom % 300) == 0, ($urandom % 60) == 0, ($urandom % 4) != 0,
              1'($urandom), ($urandom % 3) != 0);
      end
      repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("sb_drain", q_m.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
